// File: rtl/mul4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul4_seq_ctrl
//
// Purpose:
//   Computes an unsigned 4x4-bit product using one shared, external,
//   combinational 2x2-bit multiplier. Each operand is split into two 2-bit
//   digits. The four digit-pair partial products go to the multiplier one per
//   clock. They are shifted to their weight and accumulated, and the 8-bit
//   result is presented together with a one-cycle done pulse.
//
// Ports:
//   clk_i         system clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset, overrides every other input
//   start_i       request, only looked at in IDLE or DONE
//   a_i[3:0]      multiplicand, captured when a request is accepted
//   b_i[3:0]      multiplier, captured when a request is accepted
//   mul_a_o[1:0]  digit presented to port A of the shared 2x2 multiplier
//   mul_b_o[1:0]  digit presented to port B of the shared 2x2 multiplier
//   mul_result_i  combinational 2x2 product, consumed in the same cycle
//   product_o     registered 8-bit product, held until the next completion
//   busy_o        high while the four partial products are being issued
//   done_o        one-cycle pulse when product_o has just been updated
// ---------------------------------------------------------------------------
module mul4_seq_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [1:0] mul_a_o,
  output logic [1:0] mul_b_o,
  input  logic [3:0] mul_result_i,
  output logic [7:0] product_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state_q;
  logic [3:0] ra_q;
  logic [3:0] rb_q;
  logic [7:0] acc_q;
  logic [7:0] product_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] mulA_q;
  logic [1:0] mulB_q;

  logic [7:0] ppWide;
  logic [7:0] ppShifted;
  logic [7:0] acc_d;

  // Weight the current partial product by its digit position. The low x low
  // product has weight 1. The two cross products have weight 4. The high x
  // high product has weight 16. The shifted value is added to the running sum.
  // In PP3 this sum is the final product. The sum never exceeds 225, so eight
  // bits cannot wrap.
  always_comb begin
    ppWide    = {4'b0000, mul_result_i};
    ppShifted = ppWide;
    case (state_q)
      PP1, PP2: ppShifted = ppWide << 2;
      PP3:      ppShifted = ppWide << 4;
      default:  ppShifted = ppWide;
    endcase
    acc_d = acc_q + ppShifted;
  end

  // Sequencer. The multiplier digits are registered on the edge that enters
  // each PPx state. This way mul_a_o/mul_b_o already hold the digits for that
  // state during the whole cycle. They come only from captured operands.
  // The one exception is the accepting edge, where the captured value and
  // the digit are loaded together. IDLE and DONE share the request-accept
  // path, so a start held through DONE chains a new operation without a gap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ra_q      <= 4'h0;
      rb_q      <= 4'h0;
      acc_q     <= 8'h00;
      product_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mulA_q    <= 2'b00;
      mulB_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            ra_q    <= a_i;
            rb_q    <= b_i;
            acc_q   <= 8'h00;
            mulA_q  <= a_i[1:0];
            mulB_q  <= b_i[1:0];
            busy_q  <= 1'b1;
            state_q <= PP0;
          end else begin
            mulA_q  <= 2'b00;
            mulB_q  <= 2'b00;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        PP0: begin
          acc_q   <= acc_d;
          mulA_q  <= ra_q[3:2];
          mulB_q  <= rb_q[1:0];
          state_q <= PP1;
        end
        PP1: begin
          acc_q   <= acc_d;
          mulA_q  <= ra_q[1:0];
          mulB_q  <= rb_q[3:2];
          state_q <= PP2;
        end
        PP2: begin
          acc_q   <= acc_d;
          mulA_q  <= ra_q[3:2];
          mulB_q  <= rb_q[3:2];
          state_q <= PP3;
        end
        PP3: begin
          product_q <= acc_d;
          mulA_q    <= 2'b00;
          mulB_q    <= 2'b00;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        default: begin
          mulA_q  <= 2'b00;
          mulB_q  <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mul_a_o   = mulA_q;
  assign mul_b_o   = mulB_q;
  assign product_o = product_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul4_seq_ctrl
//
// Purpose:
//   Directed bench for mul4_seq_ctrl. A behavioural 2x2 multiplier stands in
//   for the shared external instance. Inputs change 1 time unit after the
//   rising edge, and registered outputs are also observed there.
// ---------------------------------------------------------------------------
module tb_mul4_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] mulA;
  logic [1:0] mulB;
  logic [3:0] mulResult;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  mul4_seq_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .a_i          (a),
    .b_i          (b),
    .mul_a_o      (mulA),
    .mul_b_o      (mulB),
    .mul_result_i (mulResult),
    .product_o    (product),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Stand-in for the shared combinational 2x2 multiplier
  assign mulResult = {2'b00, mulA} * {2'b00, mulB};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request inputs
  task automatic applyStimulus(input logic s, input logic [3:0] av, input logic [3:0] bv);
    start = s;
    a     = av;
    b     = bv;
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Single request: verify busy through PP0..PP3, then the done cycle, then
  // the return to IDLE with the product held
  task automatic runOp(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] expProduct, input string tag);
    applyStimulus(1'b1, av, bv);
    tick();
    applyStimulus(1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_busy"}, {7'd0, busy}, 8'd1);
      checkOutput({tag, "_nodone"}, {7'd0, done}, 8'd0);
      tick();
    end
    checkOutput({tag, "_done"}, {7'd0, done}, 8'd1);
    checkOutput({tag, "_busyDone"}, {7'd0, busy}, 8'd0);
    checkOutput({tag, "_product"}, product, expProduct);
    tick();
    checkOutput({tag, "_doneLow"}, {7'd0, done}, 8'd0);
    checkOutput({tag, "_hold"}, product, expProduct);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_product", product, 8'd0);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_mulA", {6'd0, mulA}, 8'd0);
    checkOutput("rst_mulB", {6'd0, mulB}, 8'd0);
    rst = 1'b0;
    tick();

    $display("[TB] 2 x 3 with digit sequence");
    applyStimulus(1'b1, 4'd2, 4'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("t1_pp0_a", {6'd0, mulA}, 8'd2);
    checkOutput("t1_pp0_b", {6'd0, mulB}, 8'd3);
    checkOutput("t1_pp0_busy", {7'd0, busy}, 8'd1);
    tick();
    checkOutput("t1_pp1_a", {6'd0, mulA}, 8'd0);
    checkOutput("t1_pp1_b", {6'd0, mulB}, 8'd3);
    tick();
    checkOutput("t1_pp2_a", {6'd0, mulA}, 8'd2);
    checkOutput("t1_pp2_b", {6'd0, mulB}, 8'd0);
    tick();
    checkOutput("t1_pp3_a", {6'd0, mulA}, 8'd0);
    checkOutput("t1_pp3_b", {6'd0, mulB}, 8'd0);
    checkOutput("t1_pp3_busy", {7'd0, busy}, 8'd1);
    checkOutput("t1_pp3_nodone", {7'd0, done}, 8'd0);
    tick();
    checkOutput("t1_done", {7'd0, done}, 8'd1);
    checkOutput("t1_busy0", {7'd0, busy}, 8'd0);
    checkOutput("t1_product", product, 8'd6);
    checkOutput("t1_done_mulA", {6'd0, mulA}, 8'd0);
    tick();
    checkOutput("t1_idle_done", {7'd0, done}, 8'd0);
    checkOutput("t1_idle_product", product, 8'd6);

    $display("[TB] 15 x 15");
    applyStimulus(1'b1, 4'd15, 4'd15);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_pp9", {4'd0, mulResult}, 8'd9);
      tick();
    end
    checkOutput("t2_done", {7'd0, done}, 8'd1);
    checkOutput("t2_product", product, 8'hE1);
    tick();

    $display("[TB] zero operands");
    runOp(4'd0, 4'd13, 8'd0, "t3a");
    runOp(4'd9, 4'd0, 8'd0, "t3b");
    tick();
    checkOutput("t3_idle_product", product, 8'd0);
    checkOutput("t3_idle_busy", {7'd0, busy}, 8'd0);

    $display("[TB] start and operand changes while busy");
    applyStimulus(1'b1, 4'd5, 4'd6);
    tick();
    applyStimulus(1'b0, 4'd5, 4'd6);
    tick();
    applyStimulus(1'b1, 4'd15, 4'd15);
    tick();
    applyStimulus(1'b0, 4'd3, 4'd3);
    checkOutput("t4_pp2_a", {6'd0, mulA}, 8'd1);
    checkOutput("t4_pp2_b", {6'd0, mulB}, 8'd1);
    tick();
    checkOutput("t4_pp3_a", {6'd0, mulA}, 8'd1);
    checkOutput("t4_pp3_b", {6'd0, mulB}, 8'd1);
    tick();
    checkOutput("t4_done", {7'd0, done}, 8'd1);
    checkOutput("t4_product", product, 8'd30);
    tick();
    checkOutput("t4_idle_done", {7'd0, done}, 8'd0);
    checkOutput("t4_idle_busy", {7'd0, busy}, 8'd0);
    tick();
    checkOutput("t4_no2nd_done", {7'd0, done}, 8'd0);
    checkOutput("t4_no2nd_busy", {7'd0, busy}, 8'd0);
    checkOutput("t4_hold", product, 8'd30);

    $display("[TB] back-to-back with start held");
    applyStimulus(1'b1, 4'd7, 4'd11);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t5_done1", {7'd0, done}, 8'd1);
    checkOutput("t5_product1", product, 8'd77);
    applyStimulus(1'b1, 4'd3, 4'd4);
    tick();
    checkOutput("t5_pp0_busy", {7'd0, busy}, 8'd1);
    checkOutput("t5_pp0_done", {7'd0, done}, 8'd0);
    checkOutput("t5_pp0_a", {6'd0, mulA}, 8'd3);
    checkOutput("t5_pp0_b", {6'd0, mulB}, 8'd0);
    checkOutput("t5_pp0_hold", product, 8'd77);
    tick();
    tick();
    tick();
    checkOutput("t5_pp3_hold", product, 8'd77);
    tick();
    checkOutput("t5_done2", {7'd0, done}, 8'd1);
    checkOutput("t5_product2", product, 8'd12);
    applyStimulus(1'b0, 4'd0, 4'd0);
    tick();
    checkOutput("t5_idle_done", {7'd0, done}, 8'd0);
    checkOutput("t5_idle_busy", {7'd0, busy}, 8'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 4'd12, 4'd10);
    tick();
    applyStimulus(1'b0, 4'd12, 4'd10);
    tick();
    tick();
    checkOutput("t6_pp2_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 4'd12, 4'd10);
    tick();
    checkOutput("t6_rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("t6_rst_done", {7'd0, done}, 8'd0);
    checkOutput("t6_rst_product", product, 8'd0);
    checkOutput("t6_rst_mulA", {6'd0, mulA}, 8'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0);
    tick();
    checkOutput("t6_dropped_busy", {7'd0, busy}, 8'd0);
    checkOutput("t6_dropped_done", {7'd0, done}, 8'd0);
    tick();
    checkOutput("t6_still_idle", {7'd0, busy}, 8'd0);
    runOp(4'd12, 4'd10, 8'd120, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
